// File: rtl/dms_lock_det.sv
// Digital lock detector for the DMS PLL: measures feedback edge count and PFD activity
// over fixed refclk windows and qualifies lock/lock-loss with a window-driven FSM.
module dms_lock_det #(
    parameter int WIN_LEN     = 64,
    parameter int EXP_CNT     = 16,
    parameter int TOL         = 1,
    parameter int PH_MAX      = 8,
    parameter int LOCK_WINS   = 4,
    parameter int UNLOCK_WINS = 2,
    parameter int CW          = 8
) (
    input  logic          refclk,
    input  logic          rst,
    input  logic          fbclk,
    input  logic          up,
    input  logic          down,
    output logic          lock,
    output logic          win_done,
    output logic          slip_err,
    output logic [CW-1:0] last_cnt,
    output logic [1:0]    state_o
);

    localparam int WW   = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
    localparam int RMAX = (LOCK_WINS > UNLOCK_WINS) ? LOCK_WINS : UNLOCK_WINS;
    localparam int RW   = $clog2(RMAX + 1);

    localparam logic [WW-1:0] WIN_LAST   = WW'(WIN_LEN - 1);
    localparam logic [CW:0]   EXP_W      = (CW+1)'(EXP_CNT);
    localparam logic [CW:0]   TOL_W      = (CW+1)'(TOL);
    localparam logic [CW:0]   PH_MAX_W   = (CW+1)'(PH_MAX);
    localparam logic [RW-1:0] LOCK_RUN   = RW'(LOCK_WINS);
    localparam logic [RW-1:0] UNLOCK_RUN = RW'(UNLOCK_WINS);

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_ACQUIRE  = 2'd1,
        ST_LOCKED   = 2'd2,
        ST_SLIP     = 2'd3
    } state_t;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] val, input logic inc);
        return (inc && (val != {CW{1'b1}})) ? val + CW'(1) : val;
    endfunction

    logic [2:0]    fb_sync_q;
    logic [1:0]    up_sync_q;
    logic [1:0]    dn_sync_q;
    logic [WW-1:0] win_cnt_q,  win_cnt_d;
    logic [CW-1:0] edge_cnt_q, edge_cnt_d;
    logic [CW-1:0] ph_cnt_q,   ph_cnt_d;
    logic [CW-1:0] last_cnt_q, last_cnt_d;
    logic [RW-1:0] run_q,      run_d;
    state_t        state_q,    state_d;
    logic          lock_q, win_done_q, slip_err_q;
    logic          slip_d;

    logic          fb_edge_s, ph_act_s, win_end_s, good_s;
    logic [CW-1:0] edge_total_s, ph_total_s;
    logic [CW:0]   total_ext_s, diff_s;

    // Synchroniser chains for the asynchronous feedback clock and PFD pulses
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            fb_sync_q <= 3'b000;
            up_sync_q <= 2'b00;
            dn_sync_q <= 2'b00;
        end else begin
            fb_sync_q <= {fb_sync_q[1:0], fbclk};
            up_sync_q <= {up_sync_q[0], up};
            dn_sync_q <= {dn_sync_q[0], down};
        end
    end

    assign fb_edge_s = fb_sync_q[1] & ~fb_sync_q[2];
    assign ph_act_s  = up_sync_q[1] | dn_sync_q[1];
    assign win_end_s = (win_cnt_q == WIN_LAST);

    // The end-cycle event still belongs to the closing window
    assign edge_total_s = sat_inc(edge_cnt_q, fb_edge_s);
    assign ph_total_s   = sat_inc(ph_cnt_q, ph_act_s);
    assign total_ext_s  = {1'b0, edge_total_s};
    assign diff_s       = (total_ext_s >= EXP_W) ? (total_ext_s - EXP_W) : (EXP_W - total_ext_s);
    assign good_s       = (diff_s <= TOL_W) && ({1'b0, ph_total_s} <= PH_MAX_W);

    // Window, edge, phase and captured-count next-state logic
    always_comb begin
        win_cnt_d  = win_cnt_q + WW'(1);
        edge_cnt_d = edge_total_s;
        ph_cnt_d   = ph_total_s;
        last_cnt_d = last_cnt_q;
        if (win_end_s) begin
            win_cnt_d  = '0;
            edge_cnt_d = '0;
            ph_cnt_d   = '0;
            last_cnt_d = edge_total_s;
        end else begin
            last_cnt_d = last_cnt_q;
        end
    end

    // Lock qualification FSM, advanced only at window end
    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        slip_d  = 1'b0;
        if (win_end_s) begin
            case (state_q)
                ST_UNLOCKED: begin
                    if (good_s) begin
                        if (LOCK_WINS == 1) begin
                            state_d = ST_LOCKED;
                            run_d   = '0;
                        end else begin
                            state_d = ST_ACQUIRE;
                            run_d   = RW'(1);
                        end
                    end else begin
                        run_d = '0;
                    end
                end
                ST_ACQUIRE: begin
                    if (!good_s) begin
                        state_d = ST_UNLOCKED;
                        run_d   = '0;
                    end else if ((run_q + RW'(1)) >= LOCK_RUN) begin
                        state_d = ST_LOCKED;
                        run_d   = '0;
                    end else begin
                        run_d = run_q + RW'(1);
                    end
                end
                ST_LOCKED: begin
                    if (good_s) begin
                        run_d = '0;
                    end else if (UNLOCK_WINS == 1) begin
                        state_d = ST_UNLOCKED;
                        run_d   = '0;
                        slip_d  = 1'b1;
                    end else begin
                        state_d = ST_SLIP;
                        run_d   = RW'(1);
                    end
                end
                ST_SLIP: begin
                    if (good_s) begin
                        state_d = ST_LOCKED;
                        run_d   = '0;
                    end else if ((run_q + RW'(1)) >= UNLOCK_RUN) begin
                        state_d = ST_UNLOCKED;
                        run_d   = '0;
                        slip_d  = 1'b1;
                    end else begin
                        run_d = run_q + RW'(1);
                    end
                end
                default: begin
                    state_d = ST_UNLOCKED;
                    run_d   = '0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Counters, FSM state and registered outputs
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            win_cnt_q  <= '0;
            edge_cnt_q <= '0;
            ph_cnt_q   <= '0;
            last_cnt_q <= '0;
            run_q      <= '0;
            state_q    <= ST_UNLOCKED;
            lock_q     <= 1'b0;
            win_done_q <= 1'b0;
            slip_err_q <= 1'b0;
        end else begin
            win_cnt_q  <= win_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            ph_cnt_q   <= ph_cnt_d;
            last_cnt_q <= last_cnt_d;
            run_q      <= run_d;
            state_q    <= state_d;
            lock_q     <= (state_d == ST_LOCKED) || (state_d == ST_SLIP);
            win_done_q <= win_end_s;
            slip_err_q <= slip_d;
        end
    end

    assign lock     = lock_q;
    assign win_done = win_done_q;
    assign slip_err = slip_err_q;
    assign last_cnt = last_cnt_q;
    assign state_o  = state_q;

endmodule
